// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : fetch_queue
// Description : In-order {pc, instruction} prefetch buffer between fetch and
//               decode, with branch-redirect flush.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_queue #(
    parameter int DEPTH  = 4,
    parameter int PC_W   = 32,
    parameter int INST_W = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_valid_i,
    input  logic [PC_W-1:0]          push_pc_i,
    input  logic [INST_W-1:0]        push_inst_i,
    output logic                     push_ready_o,
    output logic                     pop_valid_o,
    output logic [PC_W-1:0]          pop_pc_o,
    output logic [INST_W-1:0]        pop_inst_o,
    input  logic                     stall_i,
    input  logic                     flush_i,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int                  c_ADDR_W   = $clog2(DEPTH);
    localparam logic [c_ADDR_W:0]   c_FULL     = (c_ADDR_W + 1)'(DEPTH);
    localparam logic [c_ADDR_W:0]   c_CNT_ONE  = (c_ADDR_W + 1)'(1);
    localparam logic [c_ADDR_W-1:0] c_PTR_ONE  = c_ADDR_W'(1);

    logic [PC_W-1:0]     r_pc_mem   [DEPTH];
    logic [INST_W-1:0]   r_inst_mem [DEPTH];
    logic [c_ADDR_W-1:0] r_rd_ptr;
    logic [c_ADDR_W-1:0] r_wr_ptr;
    logic [c_ADDR_W:0]   r_count;

    logic w_full;
    logic w_empty;
    logic w_push_fire;
    logic w_pop_fire;

    // Ready depends only on the registered count, so fetch never sees a
    // combinational path from decode-side stall or flush.
    assign w_full       = (r_count == c_FULL);
    assign w_empty      = (r_count == '0);
    assign w_push_fire  = push_valid_i & ~w_full & ~flush_i;
    assign w_pop_fire   = ~w_empty & ~stall_i & ~flush_i;

    assign push_ready_o = ~w_full;
    assign pop_valid_o  = ~w_empty;
    assign pop_pc_o     = w_empty ? '0 : r_pc_mem[r_rd_ptr];
    assign pop_inst_o   = w_empty ? '0 : r_inst_mem[r_rd_ptr];
    assign count_o      = r_count;

    // Storage carries no reset; stale slots are masked by the count.
    always_ff @(posedge clk) begin
        if (w_push_fire) begin
            r_pc_mem[r_wr_ptr]   <= push_pc_i;
            r_inst_mem[r_wr_ptr] <= push_inst_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (flush_i) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_fire) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop_fire) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            if (w_push_fire && !w_pop_fire) begin
                r_count <= r_count + c_CNT_ONE;
            end else if (w_pop_fire && !w_push_fire) begin
                r_count <= r_count - c_CNT_ONE;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_queue
// Description : Scoreboard bench for fetch_queue: driver pushes expected
//               entries, a negedge monitor compares the head and occupancy.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_queue;

    localparam int DEPTH  = 4;
    localparam int PC_W   = 32;
    localparam int INST_W = 32;

    typedef struct {
        logic [PC_W-1:0]   pc;
        logic [INST_W-1:0] inst;
    } entry_t;

    logic                  clk;
    logic                  rst;
    logic                  push_valid_i;
    logic [PC_W-1:0]       push_pc_i;
    logic [INST_W-1:0]     push_inst_i;
    logic                  push_ready_o;
    logic                  pop_valid_o;
    logic [PC_W-1:0]       pop_pc_o;
    logic [INST_W-1:0]     pop_inst_o;
    logic                  stall_i;
    logic                  flush_i;
    logic [$clog2(DEPTH):0] count_o;

    entry_t sb[$];
    int     snap_size;
    int     n_checks;
    int     n_fail;

    fetch_queue #(
        .DEPTH  (DEPTH),
        .PC_W   (PC_W),
        .INST_W (INST_W)
    ) u_dut (
        .clk          (clk),
        .rst          (rst),
        .push_valid_i (push_valid_i),
        .push_pc_i    (push_pc_i),
        .push_inst_i  (push_inst_i),
        .push_ready_o (push_ready_o),
        .pop_valid_o  (pop_valid_o),
        .pop_pc_o     (pop_pc_o),
        .pop_inst_o   (pop_inst_o),
        .stall_i      (stall_i),
        .flush_i      (flush_i),
        .count_o      (count_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    function automatic logic [INST_W-1:0] inst_of(input logic [PC_W-1:0] pc);
        return {pc[15:0] ^ 16'hBEEF, pc[15:0] ^ 16'h1234};
    endfunction

    // Monitor: mid-cycle, compare outputs with the model and retire the head
    // when decode consumes it at the coming edge.
    always @(negedge clk) begin
        if (!rst) begin
            snap_size = sb.size();
            chk("count", 64'(count_o), 64'(snap_size));
            chk("pop_valid", 64'(pop_valid_o), 64'(snap_size != 0));
            chk("push_ready", 64'(push_ready_o), 64'(snap_size != DEPTH));
            if (snap_size != 0) begin
                chk("head_pc", 64'(pop_pc_o), 64'(sb[0].pc));
                chk("head_inst", 64'(pop_inst_o), 64'(sb[0].inst));
                if (!stall_i && !flush_i) begin
                    void'(sb.pop_front());
                end
            end else begin
                chk("empty_pc", 64'(pop_pc_o), 64'd0);
                chk("empty_inst", 64'(pop_inst_o), 64'd0);
            end
        end
    end

    // One cycle of stimulus; called at posedge+1, returns at next posedge+1.
    task automatic drive(input bit pv, input logic [PC_W-1:0] pc, input logic [INST_W-1:0] inst,
                         input bit st, input bit fl, output bit acc);
        push_valid_i = pv;
        push_pc_i    = pc;
        push_inst_i  = inst;
        stall_i      = st;
        flush_i      = fl;
        @(posedge clk);
        acc = pv && !fl && (snap_size != DEPTH);
        if (fl) begin
            sb.delete();
        end else if (acc) begin
            sb.push_back('{pc, inst});
        end
        #1;
        push_valid_i = 1'b0;
        flush_i      = 1'b0;
    endtask

    task automatic push(input logic [PC_W-1:0] pc, input bit st);
        bit acc;
        drive(1'b1, pc, inst_of(pc), st, 1'b0, acc);
    endtask

    task automatic idle(input int n);
        bit acc;
        for (int k = 0; k < n; k++) begin
            drive(1'b0, '0, '0, 1'b0, 1'b0, acc);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        bit acc;
        int tries;
        int cyc;
        n_checks     = 0;
        n_fail       = 0;
        snap_size    = 0;
        rst          = 1'b1;
        push_valid_i = 1'b0;
        push_pc_i    = '0;
        push_inst_i  = '0;
        stall_i      = 1'b0;
        flush_i      = 1'b0;

        // Reset and first-push latency
        repeat (10) @(posedge clk);
        #1;
        chk("rst_pop_valid", 64'(pop_valid_o), 64'd0);
        chk("rst_pop_pc", 64'(pop_pc_o), 64'd0);
        chk("rst_pop_inst", 64'(pop_inst_o), 64'd0);
        chk("rst_count", 64'(count_o), 64'd0);
        chk("rst_push_ready", 64'(push_ready_o), 64'd1);
        rst = 1'b0;
        drive(1'b1, 32'h0000_0000, 32'h1111_1111, 1'b1, 1'b0, acc);
        chk("lat_pop_valid", 64'(pop_valid_o), 64'd1);
        chk("lat_pc", 64'(pop_pc_o), 64'h0);
        chk("lat_inst", 64'(pop_inst_o), 64'h1111_1111);
        chk("lat_count", 64'(count_o), 64'd1);
        idle(2);

        // Fill under stall; fifth push refused, head held
        push(32'h00, 1'b1);
        push(32'h04, 1'b1);
        push(32'h08, 1'b1);
        push(32'h0C, 1'b1);
        push(32'h10, 1'b1);
        chk("fill_count", 64'(count_o), 64'd4);
        chk("fill_head", 64'(pop_pc_o), 64'h00);
        idle(5);

        // Continuous stream with alternating stall; refused offers repeat
        cyc = 0;
        for (int i = 0; i < 16; i++) begin
            tries = 0;
            acc   = 1'b0;
            while (!acc && tries < 8) begin
                drive(1'b1, 32'(i * 4), inst_of(32'(i * 4)), cyc[0], 1'b0, acc);
                cyc++;
                tries++;
            end
            if (!acc) begin
                n_checks++;
                n_fail++;
                $display("FAIL stream_accept actual=refused required=accepted pc=%0h", i * 4);
            end
        end
        idle(6);

        // Push and pop at full: push refused, then accepted
        push(32'h100, 1'b1);
        push(32'h104, 1'b1);
        push(32'h108, 1'b1);
        push(32'h10C, 1'b1);
        push(32'h110, 1'b0);
        chk("full_pop_count", 64'(count_o), 64'd3);
        push(32'h110, 1'b1);
        chk("full_repush_count", 64'(count_o), 64'd4);

        // Flush priority over a concurrent push
        idle(1);
        drive(1'b1, 32'h40, inst_of(32'h40), 1'b0, 1'b1, acc);
        chk("flush_count", 64'(count_o), 64'd0);
        chk("flush_valid", 64'(pop_valid_o), 64'd0);
        chk("flush_pc", 64'(pop_pc_o), 64'd0);
        push(32'h80, 1'b0);
        chk("post_flush_pc", 64'(pop_pc_o), 64'h80);
        idle(3);

        // Flush while empty
        drive(1'b0, '0, '0, 1'b0, 1'b1, acc);
        idle(1);

        // Asynchronous reset between edges
        push(32'hC0, 1'b1);
        push(32'hC4, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_count", 64'(count_o), 64'd0);
        chk("arst_valid", 64'(pop_valid_o), 64'd0);
        chk("arst_push_ready", 64'(push_ready_o), 64'd1);
        sb.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        stall_i = 1'b0;
        push(32'hD0, 1'b0);
        push(32'hD4, 1'b0);
        idle(4);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
